// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: takes WIDTH-bit operands, adds one 4-bit
// carry-lookahead nibble per clock (LSB first) and holds the result until it is taken.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;

  logic [3:0] a_n;
  logic [3:0] b_n;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] s;
  logic       last;

  // One 4-bit carry-lookahead slice; it is reused for every nibble in turn.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    a_n  = a_q[{idx, 2'b00} +: 4];
    b_n  = b_q[{idx, 2'b00} +: 4];
    g    = a_n & b_n;
    p    = a_n | b_n;
    c    = '0;
    s    = '0;
    c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
      s[i]   = a_n[i] ^ b_n[i] ^ c[i];
    end
    last = (idx == IDX_LAST);
  end

  // Unused encoding 2'd3 behaves exactly like IDLE.
  assign in_ready  = (state != ADD) && (state != DONE);
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ADD: begin
          sum[{idx, 2'b00} +: 4] <= s;
          carry_q                <= c[4];
          if (last) begin
            cout  <= c[4];
            ovf   <= c[3] ^ c[4];
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IDX_ONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum     <= '0;
            idx     <= '0;
            state   <= ADD;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and streaming checks for nibble_serial_adder at WIDTH=16:
// vector table, hold-under-backpressure, mid-operation reset, back-to-back random.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  typedef struct {
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } exp_t;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mc);
    exp_t        r;
    logic [16:0] full;
    full    = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
    r.esum  = full[15:0];
    r.ecout = full[16];
    r.eovf  = (ma[15] == mb[15]) && (full[15] != ma[15]);
    return r;
  endfunction

  // Issue one operation, measure latency, check result, then hand it off.
  task automatic do_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input logic [15:0] es, input logic eco, input logic eov);
    int cycles;
    @(negedge clk);
    check({nm, " in_ready before accept"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; a = ta; b = tb_; cin = tc;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom(); b = $urandom(); cin = 1'b1;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({nm, " latency"}, 64'(cycles), 64'd4);
    check({nm, " sum"}, 64'(sum), 64'(es));
    check({nm, " cout"}, 64'(cout), 64'(eco));
    check({nm, " ovf"}, 64'(ovf), 64'(eov));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " out_valid drops"}, 64'(out_valid), 64'd0);
    check({nm, " sum held in idle"}, 64'(sum), 64'(es));
  endtask

  vec_t vecs[8];

  initial begin
    int   seen;
    int   cyc;
    int   issued;
    int   results;
    int   prev;
    exp_t e;
    exp_t expq[$];

    vecs[0] = '{"ffff+1",      16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{"7fff+1",      16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{"1234+4321+c", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[3] = '{"0+0+c",       16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{"ffff+ffff+c", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{"0f0f+00f1",   16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[6] = '{"abcd+1111",   16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};
    vecs[7] = '{"8000+8000",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset sum", 64'(sum), 64'd0);
    check("reset cout", 64'(cout), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vcin,
            vecs[i].esum, vecs[i].ecout, vecs[i].eovf);

    // Reset between edges 2 and 3 after accept: partial sum and old cout/ovf vanish at once.
    @(negedge clk);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'h0000; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("partial sum before abort", 64'(sum), 64'h00FF);
    #1 rst_n = 1'b0;
    #1;
    check("abort sum", 64'(sum), 64'd0);
    check("abort cout", 64'(cout), 64'd0);
    check("abort ovf", 64'(ovf), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("aborted op never valid", 64'(seen), 64'd0);
    do_op("after abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Backpressure: result held 5 cycles while stray in_valid pulses are ignored.
    @(negedge clk);
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("hold latency", 64'(cyc), 64'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      @(negedge clk);
      check("hold out_valid", 64'(out_valid), 64'd1);
      check("hold sum", 64'(sum), 64'h5556);
      check("hold in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold release", 64'(out_valid), 64'd0);

    // Back-to-back stream, one result every 6 cycles.
    issued = 0; results = 0; prev = -1; cyc = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (results < 1000 && cyc < 10000) begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          check("unexpected result", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          check("stream sum", 64'(sum), 64'(e.esum));
          check("stream cout", 64'(cout), 64'(e.ecout));
          check("stream ovf", 64'(ovf), 64'(e.eovf));
        end
        if (prev >= 0) check("stream interval", 64'(cyc - prev), 64'd6);
        prev = cyc;
        results++;
      end
      if (in_ready) begin
        if (issued < 1000) begin
          a = $urandom(); b = $urandom(); cin = $urandom_range(1, 0);
          expq.push_back(model(a, b, cin));
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        a = $urandom(); b = $urandom(); cin = $urandom_range(1, 0);
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream result count", 64'(results), 64'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
